// File: rtl/e_mdu_sequencer_if.sv
// E-stage multiply/divide request and HI/LO result bundle.
// CANCEL is present only when MDU_CANCEL_EN is defined.
interface e_mdu_sequencer_if;
  logic        START_E;
  logic [2:0]  MDOP_E;
  logic [31:0] A_E;
  logic [31:0] B_E;
  logic        MDUSE_D;
`ifdef MDU_CANCEL_EN
  logic        CANCEL;
`endif
  logic        BUSY_E;
  logic        STALL_MD;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
`ifdef MDU_CANCEL_EN
    output CANCEL,
`endif
    output START_E, MDOP_E, A_E, B_E, MDUSE_D,
    input  BUSY_E, STALL_MD, HI, LO
  );

  modport slave (
`ifdef MDU_CANCEL_EN
    input  CANCEL,
`endif
    input  START_E, MDOP_E, A_E, B_E, MDUSE_D,
    output BUSY_E, STALL_MD, HI, LO
  );
endinterface

// File: rtl/e_mdu_sequencer.sv
// Multi-cycle mult/div sequencer owning HI/LO, with busy tracking and D-stage stall.
// Optional abort of in-flight ops via CANCEL when MDU_CANCEL_EN is defined.
module e_mdu_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  e_mdu_sequencer_if.slave  md
);
  localparam int unsigned DW = 32;
  localparam int unsigned PW = 64;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic [DW-1:0]   hi_q, hi_d, lo_q, lo_d, sh_q, sh_d, sl_q, sl_d;

  logic            start_md_c;
  logic [PW-1:0]   prod_s_c, prod_u_c;
  logic [DW-1:0]   div_b_c, q_s_c, r_s_c, q_u_c, r_u_c;
  logic            b_zero_c, div_ovf_c;

  assign start_md_c = md.START_E && (md.MDOP_E >= 3'd1) && (md.MDOP_E <= 3'd4);

  // Result datapath; divisor forced nonzero so the zero case stays defined.
  assign prod_s_c  = PW'($signed(PW'($signed(md.A_E))) * $signed(PW'($signed(md.B_E))));
  assign prod_u_c  = PW'(md.A_E) * PW'(md.B_E);
  assign b_zero_c  = (md.B_E == '0);
  assign div_b_c   = b_zero_c ? DW'(1) : md.B_E;
  assign div_ovf_c = (md.A_E == 32'h8000_0000) && (md.B_E == 32'hFFFF_FFFF);
  assign q_s_c     = div_ovf_c ? 32'h8000_0000 : DW'($signed(md.A_E) / $signed(div_b_c));
  assign r_s_c     = div_ovf_c ? '0            : DW'($signed(md.A_E) % $signed(div_b_c));
  assign q_u_c     = md.A_E / div_b_c;
  assign r_u_c     = md.A_E % div_b_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      sh_q    <= '0;
      sl_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sh_q    <= sh_d;
      sl_q    <= sl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sh_d    = sh_q;
    sl_d    = sl_q;
`ifdef MDU_CANCEL_EN
    if (md.CANCEL) begin
      state_d = IDLE;
      cnt_d   = '0;
      busy_d  = 1'b0;
    end else
`endif
    begin
      case (state_q)
        IDLE: begin
          if (md.START_E) begin
            case (md.MDOP_E)
              3'd1: {sh_d, sl_d} = prod_s_c;
              3'd2: {sh_d, sl_d} = prod_u_c;
              // Zero divisor commits the current HI/LO back unchanged.
              3'd3: {sh_d, sl_d} = b_zero_c ? {hi_q, lo_q} : {r_s_c, q_s_c};
              3'd4: {sh_d, sl_d} = b_zero_c ? {hi_q, lo_q} : {r_u_c, q_u_c};
              3'd5: hi_d = md.A_E;
              3'd6: lo_d = md.A_E;
              default: ;
            endcase
            if (start_md_c) begin
              state_d = RUN;
              busy_d  = 1'b1;
              cnt_d   = (md.MDOP_E <= 3'd2) ? CNT_W'(MULT_CYCLES - 1)
                                            : CNT_W'(DIV_CYCLES - 1);
            end
          end
        end
        RUN: begin
          if (cnt_q == '0) begin
            hi_d    = sh_q;
            lo_d    = sl_q;
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign md.BUSY_E   = busy_q;
  assign md.STALL_MD = md.MDUSE_D & (busy_q | start_md_c);
  assign md.HI       = hi_q;
  assign md.LO       = lo_q;
endmodule
